// File: rtl/decode_regbank.sv
// -----------------------------------------------------------------------------
// decode_regbank
//
// Register bank for the decode stage. It holds the general register file, the
// HI/LO pair, a pending-write counter per register, and the load-use / HI-LO
// stall logic. Decode reserves a destination at issue and writeback releases
// it. Operand reads are combinational, and so is the Stall flag.
//
// Optional feature (compile-time macro): DECODE_BYPASS_EN
//   defined   : a same-cycle writeback is forwarded to BusA/BusB/Hout/Lout.
//               That writeback also discounts the pending count used for Stall.
//   undefined : reads return stored values only. A consumer therefore stalls
//               through the writeback cycle.
//
// Parameters:
//   DATA_W  register and HI/LO width
//   ADDR_W  register address width (NREG = 2**ADDR_W)
//   PEND_W  pending counter width (max outstanding writes = 2**PEND_W-1)
//
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Ra, Rb                read addresses
//   ReadAEn, ReadBEn      operand is used (gates the stall)
//   BusA, BusB            read data
//   WE, Rw, BusW          register writeback
//   WEHI, WELO            HI/LO write enables
//   HiIn, LoIn            HI/LO write data
//   Hout, Lout            HI/LO read data
//   ReadHiLo              current instruction reads HI or LO
//   IssueWr, IssueRd      reserve destination register at issue
//   IssueReady            IssueRd can accept another reservation
//   IssueHiLo             issue of a HI/LO producing op
//   HiLoBusy              HI/LO result outstanding
//   FlushPend             squash: clear all scoreboard state
//   Stall                 operand hazard, freezes IF/ID
// -----------------------------------------------------------------------------
module decode_regbank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    input  logic              ReadAEn,
    input  logic              ReadBEn,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Rw,
    input  logic [DATA_W-1:0] BusW,
    input  logic              WEHI,
    input  logic              WELO,
    input  logic [DATA_W-1:0] HiIn,
    input  logic [DATA_W-1:0] LoIn,
    output logic [DATA_W-1:0] Hout,
    output logic [DATA_W-1:0] Lout,
    input  logic              ReadHiLo,
    input  logic              IssueWr,
    input  logic [ADDR_W-1:0] IssueRd,
    output logic              IssueReady,
    input  logic              IssueHiLo,
    output logic              HiLoBusy,
    input  logic              FlushPend,
    output logic              Stall
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    // Architectural state
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // Scoreboard state
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];
    logic              hilo_busy_q, hilo_busy_d;

    // Per-cycle decode of the control inputs
    logic              wb_hit;
    logic              issue_acc;
    logic [PEND_W-1:0] epend_a, epend_b;
    logic              hilo_busy_eff;

    // Register 0 is never a writeback target.
    assign wb_hit     = WE && (Rw != '0);
    assign IssueReady = (pend_q[IssueRd] != PEND_MAX);
    // A flush squashes the issue in the same cycle. Register 0 is never reserved.
    assign issue_acc  = IssueWr && IssueReady && (IssueRd != '0) && !FlushPend;
    assign HiLoBusy   = hilo_busy_q;

    // ------------------------------------------------------------------
    // Operand read path
    // ------------------------------------------------------------------
    always_comb begin
        BusA = (Ra == '0) ? '0 : regs_q[Ra];
        BusB = (Rb == '0) ? '0 : regs_q[Rb];
        Hout = hi_q;
        Lout = lo_q;
`ifdef DECODE_BYPASS_EN
        // wb_hit already excludes Rw==0, so register 0 is never bypassed.
        if (wb_hit && (Rw == Ra)) BusA = BusW;
        if (wb_hit && (Rw == Rb)) BusB = BusW;
        if (WEHI) Hout = HiIn;
        if (WELO) Lout = LoIn;
`endif
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        epend_a = pend_q[Ra];
        epend_b = pend_q[Rb];
`ifdef DECODE_BYPASS_EN
        // The writeback in flight this cycle is already satisfied by the bypass.
        if (wb_hit && (Rw == Ra) && (epend_a != '0)) epend_a = epend_a - PEND_ONE;
        if (wb_hit && (Rw == Rb) && (epend_b != '0)) epend_b = epend_b - PEND_ONE;
        hilo_busy_eff = hilo_busy_q && !(WEHI || WELO);
`else
        hilo_busy_eff = hilo_busy_q;
`endif
        Stall = (ReadAEn && (Ra != '0) && (epend_a != '0)) ||
                (ReadBEn && (Rb != '0) && (epend_b != '0)) ||
                (ReadHiLo && hilo_busy_eff);
    end

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
            if (FlushPend) begin
                pend_d[r] = '0;
            end else if (issue_acc && (IssueRd == ADDR_W'(r)) &&
                         !(wb_hit && (Rw == ADDR_W'(r)))) begin
                // issue_acc already guarantees that the counter is below the maximum.
                pend_d[r] = pend_q[r] + PEND_ONE;
            end else if (wb_hit && (Rw == ADDR_W'(r)) &&
                         !(issue_acc && (IssueRd == ADDR_W'(r))) &&
                         (pend_q[r] != '0)) begin
                // Saturate at zero. Writebacks of ops squashed by a flush or a
                // reset land here.
                pend_d[r] = pend_q[r] - PEND_ONE;
            end
        end
    end

    always_comb begin
        hilo_busy_d = hilo_busy_q;
        if (FlushPend)
            hilo_busy_d = 1'b0;
        else if (IssueHiLo)
            hilo_busy_d = 1'b1;         // set wins over a same-cycle result
        else if (WEHI || WELO)
            hilo_busy_d = 1'b0;
    end

    always_comb begin
        hi_d = WEHI ? HiIn : hi_q;
        lo_d = WELO ? LoIn : lo_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            hi_q        <= '0;
            lo_q        <= '0;
            hilo_busy_q <= 1'b0;
        end else begin
            // A flush does not block the register write.
            if (wb_hit) regs_q[Rw] <= BusW;
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            hilo_busy_q <= hilo_busy_d;
        end
    end

endmodule

// File: tb/tb_decode_regbank.sv
`timescale 1ns/1ps
module tb_decode_regbank;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int PEND_W = 2;
    localparam int NREG   = 32;
    localparam int PMAX   = 3;
`ifdef DECODE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              Clk;
    logic              Rst_n;
    logic [ADDR_W-1:0] Ra, Rb, Rw, IssueRd;
    logic              ReadAEn, ReadBEn, WE, WEHI, WELO, ReadHiLo;
    logic              IssueWr, IssueHiLo, FlushPend;
    logic [DATA_W-1:0] BusW, HiIn, LoIn;
    logic [DATA_W-1:0] BusA, BusB, Hout, Lout;
    logic              IssueReady, HiLoBusy, Stall;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural contents and outstanding-write counts
    logic [31:0] m_regs [NREG];
    logic [31:0] m_hi, m_lo;
    int          m_pend [NREG];
    bit          m_busy;

    decode_regbank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(PEND_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Ra(Ra), .Rb(Rb), .ReadAEn(ReadAEn), .ReadBEn(ReadBEn),
        .BusA(BusA), .BusB(BusB),
        .WE(WE), .Rw(Rw), .BusW(BusW),
        .WEHI(WEHI), .WELO(WELO), .HiIn(HiIn), .LoIn(LoIn),
        .Hout(Hout), .Lout(Lout), .ReadHiLo(ReadHiLo),
        .IssueWr(IssueWr), .IssueRd(IssueRd), .IssueReady(IssueReady),
        .IssueHiLo(IssueHiLo), .HiLoBusy(HiLoBusy),
        .FlushPend(FlushPend), .Stall(Stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_hi   = '0;
        m_lo   = '0;
        m_busy = 1'b0;
    endtask

    // Outstanding writes still owed to r once this cycle's writeback is counted.
    function automatic int owed(input int r);
        int p;
        p = m_pend[r];
        if (BYP && WE && (int'(Rw) == r) && p > 0) p = p - 1;
        return p;
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (a == 0) return 32'h0;
        if (BYP && WE && (int'(Rw) == a)) return BusW;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        bit s;
        s = 1'b0;
        if (ReadAEn && Ra != 0 && owed(int'(Ra)) > 0) s = 1'b1;
        if (ReadBEn && Rb != 0 && owed(int'(Rb)) > 0) s = 1'b1;
        if (ReadHiLo && m_busy && !(BYP && (WEHI || WELO))) s = 1'b1;
        return s;
    endfunction

    // Apply this cycle's inputs to the model at the clock edge.
    task automatic model_update();
        if (!Rst_n) begin
            model_reset();
            return;
        end
        if (WE && Rw != 0) m_regs[Rw] = BusW;
        if (WEHI) m_hi = HiIn;
        if (WELO) m_lo = LoIn;
        if (FlushPend) begin
            for (int r = 0; r < NREG; r++) m_pend[r] = 0;
            m_busy = 1'b0;
        end else begin
            if (IssueWr && IssueRd != 0 && m_pend[IssueRd] < PMAX)
                m_pend[IssueRd] = m_pend[IssueRd] + 1;
            if (WE && Rw != 0 && m_pend[Rw] > 0)
                m_pend[Rw] = m_pend[Rw] - 1;
            if (IssueHiLo) m_busy = 1'b1;
            else if (WEHI || WELO) m_busy = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        Ra = '0; Rb = '0; ReadAEn = 0; ReadBEn = 0;
        WE = 0; Rw = '0; BusW = '0;
        WEHI = 0; WELO = 0; HiIn = '0; LoIn = '0; ReadHiLo = 0;
        IssueWr = 0; IssueRd = '0; IssueHiLo = 0; FlushPend = 0;
    endtask

    task automatic check_all(input string tag);
        #1;
        check({tag, ".BusA"},       BusA,       exp_read(int'(Ra)));
        check({tag, ".BusB"},       BusB,       exp_read(int'(Rb)));
        check({tag, ".Hout"},       Hout,       (BYP && WEHI) ? HiIn : m_hi);
        check({tag, ".Lout"},       Lout,       (BYP && WELO) ? LoIn : m_lo);
        check({tag, ".Stall"},      32'(Stall), 32'(exp_stall()));
        check({tag, ".IssueReady"}, 32'(IssueReady), 32'(m_pend[IssueRd] < PMAX));
        check({tag, ".HiLoBusy"},   32'(HiLoBusy),   32'(m_busy));
    endtask

    initial begin
        Rst_n = 1'b1;
        idle();
        model_reset();

        // Reset asserted mid-cycle takes effect immediately
        #2 Rst_n = 1'b0;
        model_reset();
        check_all("reset");
        check("reset.Stall", 32'(Stall), 32'h0);
        check("reset.IssueReady", 32'(IssueReady), 32'h1);
        @(negedge Clk) Rst_n = 1'b1;
        tick();

        // Write then read, and the dropped write to register 0
        WE = 1; Rw = 5'd5; BusW = 32'h1234_5678;
        check_all("wr5");
        tick();
        idle(); Ra = 5'd5;
        check_all("rd5");
        check("rd5.const", BusA, 32'h1234_5678);
        WE = 1; Rw = 5'd0; BusW = 32'hFFFF_FFFF;
        tick();
        idle(); Ra = 5'd0;
        check_all("rd0");
        check("rd0.const", BusA, 32'h0);

        // Load-use on r8
        IssueWr = 1; IssueRd = 5'd8;
        tick();
        idle(); Ra = 5'd8; ReadAEn = 1;
        check_all("lu.wait");
        check("lu.wait.Stall", 32'(Stall), 32'h1);
        tick();
        WE = 1; Rw = 5'd8; BusW = 32'hCAFE_0008;
        check_all("lu.wb");
        check("lu.wb.Stall", 32'(Stall), BYP ? 32'h0 : 32'h1);
        check("lu.wb.BusA", BusA, BYP ? 32'hCAFE_0008 : 32'h0);
        tick();
        WE = 0;
        check_all("lu.after");
        check("lu.after.Stall", 32'(Stall), 32'h0);
        check("lu.after.BusA", BusA, 32'hCAFE_0008);

        // Counter saturation on r3
        idle(); IssueWr = 1; IssueRd = 5'd3;
        for (int i = 0; i < 3; i++) begin
            check_all("sat.issue");
            tick();
        end
        check_all("sat.full");
        check("sat.full.IssueReady", 32'(IssueReady), 32'h0);
        tick();
        idle(); Ra = 5'd3; ReadAEn = 1; WE = 1; Rw = 5'd3;
        for (int i = 0; i < 3; i++) begin
            BusW = 32'(i + 32'h300);
            check_all("sat.wb");
            tick();
        end
        WE = 0;
        check_all("sat.empty");
        check("sat.empty.Stall", 32'(Stall), 32'h0);
        WE = 1; BusW = 32'h303;
        check_all("sat.extra_wb");
        tick();
        WE = 0; IssueWr = 1; IssueRd = 5'd3;
        tick();
        IssueWr = 0;
        check_all("sat.one");
        check("sat.one.Stall", 32'(Stall), 32'h1);
        WE = 1; BusW = 32'h304;
        tick();
        WE = 0;
        check_all("sat.clear");

        // HI/LO busy tracking
        idle(); IssueHiLo = 1;
        tick();
        idle(); ReadHiLo = 1;
        check_all("hl.wait");
        check("hl.wait.Stall", 32'(Stall), 32'h1);
        check("hl.wait.Busy", 32'(HiLoBusy), 32'h1);
        tick();
        WEHI = 1; WELO = 1; HiIn = 32'hA; LoIn = 32'hB;
        check_all("hl.wb");
        check("hl.wb.Stall", 32'(Stall), BYP ? 32'h0 : 32'h1);
        check("hl.wb.Hout", Hout, BYP ? 32'hA : 32'h0);
        tick();
        WEHI = 0; WELO = 0;
        check_all("hl.after");
        check("hl.after.Hout", Hout, 32'hA);
        check("hl.after.Lout", Lout, 32'hB);
        check("hl.after.Stall", 32'(Stall), 32'h0);
        IssueHiLo = 1; WEHI = 1; HiIn = 32'hC;
        tick();
        idle(); ReadHiLo = 1;
        check_all("hl.setwins");
        check("hl.setwins.Busy", 32'(HiLoBusy), 32'h1);
        WELO = 1; LoIn = 32'hD;
        tick();
        idle();
        check_all("hl.clear");

        // Flush discards reservations
        IssueWr = 1; IssueRd = 5'd4;
        tick();
        IssueRd = 5'd9;
        tick();
        idle(); FlushPend = 1;
        tick();
        idle(); Ra = 5'd4; Rb = 5'd9; ReadAEn = 1; ReadBEn = 1;
        check_all("fl.after");
        check("fl.after.Stall", 32'(Stall), 32'h0);
        WE = 1; Rw = 5'd4; BusW = 32'h44;
        tick();
        WE = 0;
        check_all("fl.late");
        check("fl.late.BusA", BusA, 32'h44);
        IssueWr = 1; IssueRd = 5'd4;
        tick();
        IssueWr = 0;
        check_all("fl.reissue");
        check("fl.reissue.Stall", 32'(Stall), 32'h1);
        WE = 1; Rw = 5'd4; BusW = 32'h45;
        tick();
        idle();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            Ra        = 5'($urandom_range(0, 7));
            Rb        = 5'($urandom_range(0, 7));
            ReadAEn   = ($urandom_range(0, 1) == 1);
            ReadBEn   = ($urandom_range(0, 1) == 1);
            WE        = ($urandom_range(0, 2) == 0);
            Rw        = 5'($urandom_range(0, 7));
            BusW      = $urandom();
            WEHI      = ($urandom_range(0, 5) == 0);
            WELO      = ($urandom_range(0, 5) == 0);
            HiIn      = $urandom();
            LoIn      = $urandom();
            ReadHiLo  = ($urandom_range(0, 3) == 0);
            IssueWr   = ($urandom_range(0, 1) == 0);
            IssueRd   = 5'($urandom_range(0, 7));
            IssueHiLo = ($urandom_range(0, 7) == 0);
            FlushPend = ($urandom_range(0, 29) == 0);
            check_all("rand");
            tick();
        end

        // Reset in the middle of outstanding work
        idle(); IssueWr = 1; IssueRd = 5'd6;
        tick();
        idle(); Ra = 5'd6; ReadAEn = 1;
        check_all("mr.pre");
        check("mr.pre.Stall", 32'(Stall), 32'h1);
        #2 Rst_n = 1'b0;
        model_reset();
        check_all("mr.reset");
        check("mr.reset.Stall", 32'(Stall), 32'h0);
        check("mr.reset.BusA", BusA, 32'h0);
        @(negedge Clk) Rst_n = 1'b1;
        WE = 1; Rw = 5'd6; BusW = 32'h66;
        tick();
        WE = 0;
        check_all("mr.late");
        check("mr.late.BusA", BusA, 32'h66);
        check("mr.late.Stall", 32'(Stall), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_regbank.md
# decode_regbank

Parametrised register bank for the decode stage: general register file, HI/LO pair, per-register pending-write scoreboard, and load-use/HI-LO stall generation. Decode drives read addresses and reserves destinations at issue. Writeback releases them. The bank returns operand values, optionally bypassed from the same-cycle writeback, and a Stall flag that freezes IF/ID when an operand is still in flight.

## Interface
Parameters:
- DATA_W, 32, register and HI/LO width
- ADDR_W, 5, register address width; NREG = 2**ADDR_W
- PEND_W, 2, per-register pending counter width; max outstanding writes per register = 2**PEND_W-1

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst_n  in  1  asynchronous active-low reset
- Ra, Rb  in  ADDR_W  read addresses
- ReadAEn, ReadBEn  in  1  operand actually used (gates stall)
- BusA, BusB  out  DATA_W  read data (combinational)
- WE  in  1  writeback enable
- Rw  in  ADDR_W  writeback address
- BusW  in  DATA_W  writeback data
- WEHI, WELO  in  1  HI/LO write enables
- HiIn, LoIn  in  DATA_W  HI/LO write data
- Hout, Lout  out  DATA_W  HI/LO read data (combinational)
- ReadHiLo  in  1  current instruction reads HI or LO
- IssueWr  in  1  reserve destination IssueRd
- IssueRd  in  ADDR_W  destination to reserve
- IssueReady  out  1  pend[IssueRd] < max
- IssueHiLo  in  1  issue a HI/LO-producing op (mult/div)
- HiLoBusy  out  1  HI/LO result outstanding
- FlushPend  in  1  squash: clear all scoreboard state
- Stall  out  1  operand hazard

## Operation
- Register 0 reads as 0. Writes to 0 are dropped. Issue to 0 is never counted.
- Write: on WE and Rw≠0, regs[Rw] ← BusW at the clock edge.
- HI/LO: WEHI loads HI and WELO loads LO, independently. Both may be asserted in the same cycle.
- Scoreboard counter pend[r], PEND_W bits:
  - +1 on accepted issue (IssueWr && IssueReady && IssueRd≠0)
  - −1 on WE to r
  - Issue and writeback to the same r in one cycle: net unchanged.
  - Decrement at 0 saturates at 0. This covers writebacks of squashed ops after a flush.
  - Issue while pend = max: ignored. IssueReady=0.
- Effective pending epend[r]:
  - With bypass: pend[r] minus 1 if WE && Rw==r this cycle.
  - Without bypass: pend[r].
- Stall = (ReadAEn && Ra≠0 && epend[Ra]≠0) | (ReadBEn && Rb≠0 && epend[Rb]≠0) | (ReadHiLo && HiLoBusy_eff).
  - HiLoBusy_eff is HiLoBusy cleared by a same-cycle WEHI|WELO (bypass build only).
- HiLoBusy:
  - Set on IssueHiLo. Cleared on WEHI|WELO.
  - Set and clear in the same cycle: set wins.
- FlushPend:
  - Clears all pend[] and HiLoBusy next edge.
  - Overrides a same-cycle issue.
  - Does not block a same-cycle register write.

## Timing
- Reads are zero-latency combinational. Writes are visible through the array one cycle later.
- Stall is combinational from the current-cycle inputs and state. No registered outputs.
- Reset (async assert, sync-released use):
  - All regs, HI, LO, pend[] = 0, HiLoBusy = 0.
  - Hence BusA = BusB = Hout = Lout = 0, Stall = 0, IssueReady = 1.
- Reset mid-operation discards all pending reservations. Later writebacks saturate at 0.

## Configuration
- DECODE_BYPASS_EN defined:
  - Ra/Rb matching a same-cycle writeback (WE, Rw≠0) return BusW.
  - Hout/Lout return HiIn/LoIn when WEHI/WELO is asserted.
  - Stall uses epend with the writeback discount.
- Undefined:
  - Reads return stored values only.
  - Stall holds for the writeback cycle, so the consumer proceeds one cycle later.

## Test plan
- Reset: Rst_n low mid-cycle -> BusA=BusB=Hout=Lout=0, Stall=0, IssueReady=1 immediately, HiLoBusy=0.
- Write/read: WE, Rw=5, BusW=0x1234_5678; next cycle Ra=5 -> BusA=0x12345678. Write Rw=0 with 0xFFFF_FFFF -> Ra=0 reads 0.
- Load-use:
  - Issue IssueRd=8; next cycle Ra=8, ReadAEn=1 -> Stall=1.
  - Writeback cycle: bypass build -> Stall=0 and BusA=BusW. Non-bypass -> Stall=1, clears the following cycle.
- Counter saturation (PEND_W=2): issue r3 three times -> IssueReady=0 for IssueRd=3. Fourth issue ignored. Three writebacks -> pend=0, Stall=0. A fourth writeback keeps pend at 0.
- HI/LO: IssueHiLo then ReadHiLo -> Stall=1 until WEHI=WELO=1 with HiIn=0xA, LoIn=0xB. Then Hout=0xA, Lout=0xB (same cycle if bypass). IssueHiLo in the same cycle as the writeback leaves HiLoBusy=1.
- Flush: reserve r4 and r9, assert FlushPend -> next cycle Stall=0 for both. A late WE to r4 writes data, and pend[r4] stays 0.
